// File: rtl/test_pattern_checker.sv
// test_pattern_checker
//   Receive-side checker for the on-chip test pattern generator. It predicts
//   the next captured sample for the selected pattern, locks onto the stream
//   and counts mismatching samples.
//
//   Ports:
//     clk, rst_n      clock, synchronous active-low reset
//     enable          run the checker; low parks it in IDLE
//     pattern_sel     00 increment, 01 square (256-run 00/FF), 10 LFSR,
//                     11 alternating (16-run 55/AA)
//     clear_counts    synchronous clear of error_count and sample_count
//     data_in         captured sample (pattern lives in bits [7:0])
//     data_valid      qualifier for data_in
//     locked          high while in LOCKED
//     error_pulse     one-cycle pulse per mismatching sample while LOCKED
//     error_count     saturating count of LOCKED mismatches
//     sample_count    valid samples checked while LOCKED (wraps)
//     state           00 IDLE, 01 SYNC, 10 LOCKED
//
//   Input qualifier: a sample is consumed on every rising clk edge where
//   data_valid is high; there is no back-pressure. Samples with data_valid low
//   change nothing (no state change, predictor and run counter hold).
//   All outputs are registered, so a sample's effect appears one cycle later.
module test_pattern_checker #(
    parameter int DATA_WIDTH = 8,
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 8,
    parameter int ERR_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [1:0]            pattern_sel,
    input  logic                  clear_counts,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    output logic                  locked,
    output logic                  error_pulse,
    output logic [ERR_WIDTH-1:0]  error_count,
    output logic [31:0]           sample_count,
    output logic [1:0]            state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SYNC   = 2'b01,
        ST_LOCKED = 2'b10
    } state_e;

    localparam logic [1:0] SEL_INC  = 2'b00;
    localparam logic [1:0] SEL_SQ   = 2'b01;
    localparam logic [1:0] SEL_LFSR = 2'b10;
    localparam int         MW       = $clog2(LOCK_COUNT + 1);
    localparam int         LW       = $clog2(LOSS_COUNT + 1);

    state_e                 state_q, state_d;
    logic [1:0]             sel_q, sel_d;
    // Predictor for increment/LFSR; current level for the run patterns
    // (and, while waiting for an edge in SYNC, the last legal level seen).
    logic [7:0]             exp_q, exp_d;
    // Samples of the current level already seen (run patterns only).
    logic [8:0]             run_q, run_d;
    logic [MW-1:0]          match_q, match_d;
    logic [LW-1:0]          miss_q, miss_d;
    logic                   seeded_q, seeded_d;
    logic [ERR_WIDTH-1:0]   err_q, err_d;
    logic [31:0]            samp_q, samp_d;
    logic                   pulse_q, pulse_d;

    function automatic logic [7:0] next_val(input logic [1:0] sel, input logic [7:0] x);
        if (sel == SEL_LFSR)
            return (x == 8'h00) ? 8'hA5 : {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
        else
            return x + 8'd1;
    endfunction

    logic                   is_run;
    logic [8:0]             run_len;
    logic                   run_end;
    logic [7:0]             cmp8;
    logic [7:0]             low;
    logic                   hi_zero;
    logic                   hit;
    logic [7:0]             lvl_lo;
    logic                   legal;
    logic [7:0]             adv_exp;
    logic [8:0]             adv_run;
    logic [MW-1:0]          match_inc;
    logic [LW-1:0]          miss_inc;

    assign is_run    = pattern_sel[0];
    assign run_len   = (pattern_sel == SEL_SQ) ? 9'd256 : 9'd16;
    assign run_end   = (run_q == run_len);
    // Run patterns: hold the level for run_len samples, then flip to its complement.
    assign cmp8      = (is_run && run_end) ? ~exp_q : exp_q;
    assign low       = data_in[7:0];
    // Zero-extending the low byte and comparing catches any set upper bit.
    assign hi_zero   = (data_in == DATA_WIDTH'(low));
    assign hit       = (data_in == DATA_WIDTH'(cmp8));
    assign lvl_lo    = (pattern_sel == SEL_SQ) ? 8'h00 : 8'h55;
    assign legal     = hi_zero && ((low == lvl_lo) || (low == ~lvl_lo));
    assign adv_exp   = is_run ? cmp8 : next_val(pattern_sel, exp_q);
    assign adv_run   = (is_run && !run_end) ? run_q + 9'd1 : 9'd1;
    assign match_inc = match_q + MW'(1);
    assign miss_inc  = miss_q + LW'(1);

    always_comb begin
        state_d  = state_q;
        sel_d    = pattern_sel;
        exp_d    = exp_q;
        run_d    = run_q;
        match_d  = match_q;
        miss_d   = miss_q;
        seeded_d = seeded_q;
        err_d    = err_q;
        samp_d   = samp_q;
        pulse_d  = 1'b0;

        if (!enable) begin
            state_d  = ST_IDLE;
            match_d  = '0;
            miss_d   = '0;
            seeded_d = 1'b0;
        end else if (state_q != ST_SYNC && state_q != ST_LOCKED) begin
            state_d  = ST_SYNC;
            match_d  = '0;
            seeded_d = 1'b0;
        end else if (pattern_sel != sel_q) begin
            // New pattern: resynchronise, counts are kept.
            state_d  = ST_SYNC;
            match_d  = '0;
            miss_d   = '0;
            seeded_d = 1'b0;
        end else if (data_valid) begin
            if (state_q == ST_LOCKED) begin
                // The predictor free-runs from itself so a single corrupted
                // sample costs exactly one error.
                exp_d  = adv_exp;
                if (is_run)
                    run_d = adv_run;
                samp_d = samp_q + 32'd1;
                if (hit) begin
                    miss_d = '0;
                end else begin
                    pulse_d = 1'b1;
                    if (err_q != '1)
                        err_d = err_q + ERR_WIDTH'(1);
                    miss_d = miss_inc;
                    if (miss_inc == LW'(LOSS_COUNT)) begin
                        state_d  = ST_SYNC;
                        miss_d   = '0;
                        match_d  = '0;
                        seeded_d = 1'b0;
                    end
                end
            end else begin
                if (!is_run) begin
                    // A matching sample predicts the same successor as the
                    // predictor would, so always reseed from the sample.
                    match_d  = (seeded_q && hit) ? match_inc : '0;
                    exp_d    = next_val(pattern_sel, low);
                    seeded_d = 1'b1;
                end else if (!legal) begin
                    match_d  = '0;
                    seeded_d = 1'b0;
                end else if (match_q != '0) begin
                    // Tracking a run since the last level change.
                    if (hit) begin
                        match_d = match_inc;
                        exp_d   = adv_exp;
                        run_d   = adv_run;
                    end else begin
                        match_d  = '0;
                        exp_d    = low;
                        seeded_d = 1'b1;
                    end
                end else if (seeded_q && low != exp_q) begin
                    // First level change: phase is now known.
                    exp_d   = low;
                    run_d   = 9'd1;
                    match_d = MW'(1);
                end else begin
                    exp_d    = low;
                    seeded_d = 1'b1;
                end
                if (match_d == MW'(LOCK_COUNT)) begin
                    state_d = ST_LOCKED;
                    miss_d  = '0;
                end
            end
        end

        if (clear_counts) begin
            err_d  = '0;
            samp_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            sel_q    <= '0;
            exp_q    <= '0;
            run_q    <= '0;
            match_q  <= '0;
            miss_q   <= '0;
            seeded_q <= 1'b0;
            err_q    <= '0;
            samp_q   <= '0;
            pulse_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            exp_q    <= exp_d;
            run_q    <= run_d;
            match_q  <= match_d;
            miss_q   <= miss_d;
            seeded_q <= seeded_d;
            err_q    <= err_d;
            samp_q   <= samp_d;
            pulse_q  <= pulse_d;
        end
    end

    assign state        = state_q;
    assign locked       = (state_q == ST_LOCKED);
    assign error_pulse  = pulse_q;
    assign error_count  = err_q;
    assign sample_count = samp_q;

endmodule

// File: tb/tb_test_pattern_checker.sv
// Bench for test_pattern_checker: directed scenarios followed by a random
// phase, every cycle compared against a behavioural model of the checker.
module tb_test_pattern_checker;

    localparam int DW      = 8;
    localparam int LC      = 4;
    localparam int LS      = 8;
    localparam int EW      = 10;
    localparam int ERR_MAX = (1 << EW) - 1;
    localparam int OW      = 2 + 1 + 1 + EW + 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic [1:0]    pattern_sel = 2'b00;
    logic          clear_counts = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          data_valid = 1'b0;
    logic          locked;
    logic          error_pulse;
    logic [EW-1:0] error_count;
    logic [31:0]   sample_count;
    logic [1:0]    state;

    test_pattern_checker #(
        .DATA_WIDTH(DW), .LOCK_COUNT(LC), .LOSS_COUNT(LS), .ERR_WIDTH(EW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .pattern_sel(pattern_sel),
        .clear_counts(clear_counts), .data_in(data_in), .data_valid(data_valid),
        .locked(locked), .error_pulse(error_pulse), .error_count(error_count),
        .sample_count(sample_count), .state(state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [OW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // m_state: 0 idle, 1 sync, 2 locked.  Run patterns are modelled as a
    // timeline anchored at the level-change sample: position p carries the
    // anchor level when (p / run) is even, its complement otherwise.
    int m_state, m_match, m_miss, m_seeded, m_exp, m_prev, m_anchor, m_pos;
    int m_sel_prev, m_err, m_samp, m_pulse;

    function automatic int f_next(input int sel, input int x);
        if (sel == 2) begin
            if (x == 0) return 'hA5;
            return ((x << 1) & 'hFE) | (((x >> 7) ^ (x >> 5) ^ (x >> 4) ^ (x >> 3)) & 1);
        end
        return (x + 1) % 256;
    endfunction

    function automatic int level_at(input int anchor, input int p, input int rl);
        return ((p / rl) % 2 == 1) ? (anchor ^ 'hFF) : anchor;
    endfunction

    task automatic model_reset();
        m_state = 0; m_match = 0; m_miss = 0; m_seeded = 0; m_exp = 0;
        m_prev = 0; m_anchor = 0; m_pos = 0; m_sel_prev = 0;
        m_err = 0; m_samp = 0; m_pulse = 0;
    endtask

    task automatic model_step();
        int  sel, b, e, rl, lo;
        bit  is_run, sel_chg;
        if (!rst_n) begin
            model_reset();
            return;
        end
        sel     = int'(pattern_sel);
        b       = int'(data_in);
        is_run  = (sel == 1 || sel == 3);
        rl      = (sel == 1) ? 256 : 16;
        lo      = (sel == 1) ? 'h00 : 'h55;
        sel_chg = (sel != m_sel_prev);
        m_sel_prev = sel;
        m_pulse = 0;
        if (!enable) begin
            m_state = 0; m_match = 0; m_miss = 0; m_seeded = 0;
        end else if (m_state == 0) begin
            m_state = 1; m_match = 0; m_seeded = 0;
        end else if (sel_chg) begin
            m_state = 1; m_match = 0; m_miss = 0; m_seeded = 0;
        end else if (data_valid) begin
            if (m_state == 2) begin
                e = is_run ? level_at(m_anchor, m_pos, rl) : m_exp;
                if (is_run) m_pos++;
                else m_exp = f_next(sel, m_exp);
                m_samp++;
                if (b == e) begin
                    m_miss = 0;
                end else begin
                    m_pulse = 1;
                    if (m_err < ERR_MAX) m_err++;
                    m_miss++;
                    if (m_miss == LS) begin
                        m_state = 1; m_miss = 0; m_match = 0; m_seeded = 0;
                    end
                end
            end else begin
                if (!is_run) begin
                    if (m_seeded == 1 && b == m_exp) m_match++;
                    else m_match = 0;
                    m_seeded = 1;
                    m_exp = f_next(sel, b);
                end else if (b != lo && b != (lo ^ 'hFF)) begin
                    m_match = 0; m_seeded = 0;
                end else if (m_match > 0) begin
                    if (b == level_at(m_anchor, m_pos, rl)) begin
                        m_match++; m_pos++;
                    end else begin
                        m_match = 0; m_prev = b; m_seeded = 1;
                    end
                end else if (m_seeded == 1 && b != m_prev) begin
                    m_anchor = b; m_pos = 1; m_match = 1;
                end else begin
                    m_prev = b; m_seeded = 1;
                end
                if (m_match == LC) begin
                    m_state = 2; m_miss = 0;
                end
            end
        end
        if (clear_counts) begin
            m_err = 0; m_samp = 0;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        logic [OW-1:0] e;
        model_step();
        exp_q.push_back({2'(m_state), (m_state == 2), 1'(m_pulse), EW'(m_err), 32'(m_samp)});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("state",        state,        e[OW-1 -: 2]);
        check("locked",       locked,       e[OW-3]);
        check("error_pulse",  error_pulse,  e[OW-4]);
        check("error_count",  error_count,  e[32 +: EW]);
        check("sample_count", sample_count, e[31:0]);
    endtask

    task automatic send(input int d);
        data_in    = DW'(d);
        data_valid = 1'b1;
        tick();
    endtask

    task automatic gap();
        data_valid = 1'b0;
        tick();
    endtask

    task automatic send_gappy(input int d);
        while ($urandom_range(0, 3) == 0) gap();
        send(d);
    endtask

    task automatic restart(input logic [1:0] sel);
        pattern_sel  = sel;
        clear_counts = 1'b1;
        gap();
        clear_counts = 1'b0;
    endtask

    // random-phase generator
    int g_x, g_i;

    task automatic gen_restart();
        g_x = $urandom_range(0, 255);
        g_i = $urandom_range(0, 1000);
    endtask

    function automatic int gen_val(input int sel);
        int rl, lo;
        rl = (sel == 1) ? 256 : 16;
        lo = (sel == 1) ? 'h00 : 'h55;
        if (sel == 1 || sel == 3) return ((g_i / rl) % 2 == 1) ? (lo ^ 'hFF) : lo;
        return g_x;
    endfunction

    task automatic gen_adv(input int sel);
        if (sel == 1 || sel == 3) g_i++;
        else g_x = f_next(sel, g_x);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int x, v, r, sel;
        model_reset();

        // reset
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_state", state, 2'b00);
        check("rst_err", error_count, '0);
        rst_n = 1'b1;

        // increment stream with one corrupted sample and a wrap
        enable = 1'b1;
        pattern_sel = 2'd0;
        gap();
        for (int i = 0; i < 300; i++) begin
            if (i == 'h40) begin
                send('h41);
                check("corrupt_pulse", error_pulse, 1'b1);
                check("corrupt_count", error_count, 1);
                check("corrupt_keep_lock", locked, 1'b1);
            end else begin
                send(i % 256);
            end
            if (i == 3) check("inc_not_locked_4th", locked, 1'b0);
            if (i == 4) check("inc_locked_5th", locked, 1'b1);
            if (i == 'h41) check("after_corrupt_pulse", error_pulse, 1'b0);
        end
        check("inc_err_total", error_count, 1);
        check("inc_samples", sample_count, 295);

        // LFSR stream, then eight zero samples force resync
        restart(2'd2);
        x = 0;
        for (int i = 0; i < 30; i++) begin
            send(x);
            x = f_next(2, x);
        end
        check("lfsr_locked", locked, 1'b1);
        check("lfsr_err", error_count, 0);
        check("lfsr_samples", sample_count, 25);
        for (int i = 0; i < 8; i++) send(0);
        check("lfsr_loss_err", error_count, 8);
        check("lfsr_loss_state", state, 2'b01);
        x = 0;
        for (int i = 0; i < 5; i++) begin
            send(x);
            x = f_next(2, x);
            if (i == 3) check("lfsr_relock_4", locked, 1'b0);
        end
        check("lfsr_relock_5", locked, 1'b1);

        // square pattern with random valid gaps, then one short run
        restart(2'd1);
        for (int i = 0; i < 768; i++) begin
            send_gappy(((i / 256) % 2 == 1) ? 'hFF : 'h00);
            if (i == 258) check("sq_not_locked", locked, 1'b0);
            if (i == 259) check("sq_locked", locked, 1'b1);
        end
        for (int i = 0; i < 255; i++) send_gappy('hFF);
        send('h00);
        check("sq_short_pulse", error_pulse, 1'b1);
        for (int i = 0; i < 255; i++) send_gappy('h00);
        check("sq_short_err", error_count, 1);
        check("sq_short_lock", locked, 1'b1);

        // alternating pattern, valid every other cycle, illegal value in SYNC
        restart(2'd3);
        for (int i = 0; i < 96; i++) begin
            send(((i / 16) % 2 == 1) ? 'hAA : 'h55);
            gap();
            if (i == 17) begin
                send('h12);
                check("alt_illegal_sync", state, 2'b01);
                gap();
            end
            if (i == 34) check("alt_not_locked", locked, 1'b0);
            if (i == 35) check("alt_locked", locked, 1'b1);
        end
        check("alt_err", error_count, 0);

        // error counter saturation, clear against error, reset while locked
        restart(2'd0);
        for (x = 0; x < 5; x++) send(x);
        for (int g = 0; g < 150; g++) begin
            for (int j = 0; j < 7; j++) begin
                send((x % 256) ^ 'h80);
                x++;
            end
            send(x % 256);
            x++;
        end
        check("sat_count", error_count, ERR_MAX);
        check("sat_locked", locked, 1'b1);
        clear_counts = 1'b1;
        send((x % 256) ^ 'h80);
        x++;
        clear_counts = 1'b0;
        check("clr_pulse", error_pulse, 1'b1);
        check("clr_err", error_count, 0);
        check("clr_samples", sample_count, 0);
        for (int i = 0; i < 3; i++) begin
            send(x % 256);
            x++;
        end
        rst_n = 1'b0;
        send(x % 256);
        check("rst_mid_state", state, 2'b00);
        check("rst_mid_locked", locked, 1'b0);
        check("rst_mid_samples", sample_count, 0);
        rst_n = 1'b1;

        // random phase
        gen_restart();
        for (int k = 0; k < 3000; k++) begin
            r = $urandom_range(0, 999);
            if (r < 4) begin
                pattern_sel = 2'($urandom_range(0, 3));
                gen_restart();
            end else if (r < 7) begin
                enable = 1'b0;
                gap();
                gap();
                enable = 1'b1;
            end
            clear_counts = (r >= 7 && r < 11);
            sel = int'(pattern_sel);
            if (r >= 11 && r < 14) begin
                for (int j = 0; j < 10; j++) begin
                    send(gen_val(sel) ^ 'h01);
                    gen_adv(sel);
                end
            end else if ($urandom_range(0, 3) == 0) begin
                gap();
            end else begin
                v = gen_val(sel);
                if ($urandom_range(0, 49) == 0) v = $urandom_range(0, 255);
                send(v);
                gen_adv(sel);
            end
            clear_counts = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5000000;
        n_err++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1);
    end

endmodule

// File: doc/test_pattern_checker.md
Name: test_pattern_checker

Overview:
Receive-side companion to the on-chip test pattern generator. Consumes captured samples from the logic analyzer data path, predicts the next value for the selected pattern, locks onto the stream, and counts mismatches. Used for loopback self-test of the capture path: generator → probe pins/capture → checker.

Parameters:
DATA_WIDTH, 8, sample width; pattern defined on bits [7:0], bits above 7 expected zero.
LOCK_COUNT, 4, consecutive matching samples needed to enter LOCKED (≥1).
LOSS_COUNT, 8, consecutive mismatching samples in LOCKED that force resync (≥1).
ERR_WIDTH, 16, width of saturating error counter.

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
enable  input  1  checker run; low = IDLE
pattern_sel  input  2  00 increment, 01 square (256-run 00/FF), 10 LFSR, 11 alternating (16-run 55/AA)
clear_counts  input  1  synchronous clear of error_count and sample_count
data_in  input  DATA_WIDTH  captured sample
data_valid  input  1  data_in qualifier; only valid samples are checked
locked  output  1  checker in LOCKED state
error_pulse  output  1  one-cycle pulse per mismatching sample while LOCKED
error_count  output  ERR_WIDTH  saturating count of LOCKED mismatches
sample_count  output  32  valid samples checked while LOCKED (wraps)
state  output  2  00 IDLE, 01 SYNC, 10 LOCKED

Behaviour:
- Reset (rst_n low at clk edge): state IDLE, all outputs 0, predictor and run counter 0. Reset has priority over everything.
- All outputs registered; a valid sample's effects appear on the cycle after it is presented.
- Next-value function f(x): 00 → x+1 mod 256; 10 → x==0 ? A5 : {x[6:0], x[7]^x[5]^x[4]^x[3]}. Square/alternating use level + run counter: the expected value holds for RUN samples (256 for 01, 16 for 11) and then toggles (00↔FF, 55↔AA).
- IDLE: entered when enable is low; match/miss counters cleared; error_count and sample_count held. On enable high → SYNC.
- SYNC: first valid sample seeds the predictor (expected = f(sample)); match counter = 0. Each subsequent valid sample: equals expected → match+1; otherwise reseed from the sample and set match to 0. For run patterns, a sample is legal only if it is one of the two levels; SYNC waits for the first level change, sets run counter = 1 and counts it as match 1; an illegal value resets match and waits for a new change. match == LOCK_COUNT → LOCKED.
- LOCKED: each valid sample is compared with expected; expected always advances from expected, never from received data, so a single corrupted sample produces exactly one error. Match → sample_count+1, miss counter = 0. Mismatch → error_pulse, error_count+1 (saturating at all-ones), sample_count+1, miss+1. miss == LOSS_COUNT → SYNC (predictor reseeds on the next valid sample); locked drops the cycle after that sample.
- Upper bits [DATA_WIDTH-1:8] nonzero = mismatch.
- pattern_sel change while enable is high → SYNC on the next cycle; counters held.
- data_valid low: no state change; run counter does not advance.
- clear_counts coincident with an error: clear wins, error_count = 0 afterward, error_pulse still asserts.
- Increment wrap FF→00 and LFSR 0→A5 are legal transitions.

Test Plan:
- Increment stream 00,01,…,FF,00,… every cycle, LOCK_COUNT=4 → locked rises after the 5th sample (seed + 4 matches), error_count stays 0 across the FF→00 wrap, sample_count increments per sample.
- Locked increment stream with sample 0x40 corrupted to 0x41 → exactly one error_pulse, error_count=1, lock retained, next sample 0x41 matches.
- LFSR from 00: 00, A5, 4A, 95, … → lock with no errors. Then force 8 consecutive 00 samples → error_count=8, state returns to SYNC, relock after 5 good samples.
- Square pattern: 256×00 then 256×FF, repeated → lock 4 samples after the first 00→FF edge. Shorten one run to 255 → one error_pulse at the early toggle.
- Alternating 16×55/16×AA with data_valid toggled every other cycle → no errors. Sample 0x12 during SYNC resets the match counter.
- Drive error_count to FFFF → saturates. clear_counts asserted together with an error → counts 0. rst_n low mid-LOCKED → state IDLE and all outputs 0 on the next cycle.
